// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC unit:
// next-PC select encodings and the sequential increment.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_RET = 2'b11
  } sel_e;

  localparam int PC_INC = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push/pop, top pointer and count.
// Ports: clk, reset, push, pop, din, dout (top entry), count, full, empty.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    nxt;
  logic [PW-1:0]    prv;

  // Explicit wrap so non-power-of-two depths stay circular.
  assign nxt = (top == PW'(DEPTH-1)) ? '0 : top + PW'(1);
  assign prv = (top == '0) ? PW'(DEPTH-1) : top - PW'(1);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[top];

  always_ff @(posedge clk) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
    end else if (push) begin
      // When full, writing at nxt overwrites the oldest entry.
      top <= nxt;
      if (!full)
        count <= count + CW'(1);
    end else if (pop && !empty) begin
      top   <= prv;
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[nxt] <= din;
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch PC register with next-PC mux (seq/branch/jump/return) and RAS.
// Ports: Clk, Reset, LdEn, Sel, BrTaken, Imm, Target, Call -> Dout, DoutPlus4, RasDepth, RasOvf, RasUnf.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        LdEn,
  input  logic [1:0]                  Sel,
  input  logic                        BrTaken,
  input  logic [15:0]                 Imm,
  input  logic [WIDTH-1:0]            Target,
  input  logic                        Call,
  output logic [WIDTH-1:0]            Dout,
  output logic [WIDTH-1:0]            DoutPlus4,
  output logic [$clog2(DEPTH+1)-1:0]  RasDepth,
  output logic                        RasOvf,
  output logic                        RasUnf
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] ras_top;
  logic             push;
  logic             pop_req;
  logic             ras_full;
  logic             ras_empty;

  assign Dout      = pc;
  assign DoutPlus4 = pc + WIDTH'(PC_INC);

  // Sign-extended word offset, shifted by 2 and fitted to WIDTH.
  always_comb begin
    offset = '0;
    for (int i = 2; i < WIDTH; i++)
      offset[i] = (i - 2 < 16) ? Imm[i-2] : Imm[15];
  end

  assign push    = LdEn && (Sel == SEL_JMP) && Call;
  assign pop_req = LdEn && (Sel == SEL_RET);

  always_comb begin
    pc_next = DoutPlus4;
    unique case (Sel)
      SEL_SEQ: pc_next = DoutPlus4;
      SEL_BR:  pc_next = BrTaken ? DoutPlus4 + offset : DoutPlus4;
      SEL_JMP: pc_next = Target & ~WIDTH'(3);
      SEL_RET: pc_next = ras_empty ? DoutPlus4 : ras_top;
      default: pc_next = DoutPlus4;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc     <= RESET_VEC;
      RasOvf <= 1'b0;
      RasUnf <= 1'b0;
    end else if (LdEn) begin
      pc <= pc_next;
      if (push && ras_full)
        RasOvf <= 1'b1;
      if (pop_req && ras_empty)
        RasUnf <= 1'b1;
    end
  end

  ras_stack #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk   (Clk),
    .reset (Reset),
    .push  (push),
    .pop   (pop_req),
    .din   (DoutPlus4),
    .dout  (ras_top),
    .count (RasDepth),
    .full  (ras_full),
    .empty (ras_empty)
  );

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed-vector bench for pc_ras_unit (WIDTH=32, DEPTH=4).
// Checks PC sequencing, branches, jumps, RAS push/pop, flags, stall, wrap, reset.
module tb_pc_ras_unit;

  logic        clk;
  logic        reset;
  logic        ld_en;
  logic [1:0]  sel;
  logic        br_taken;
  logic [15:0] imm;
  logic [31:0] target;
  logic        call;
  logic [31:0] dout;
  logic [31:0] dout_p4;
  logic [2:0]  depth;
  logic        ovf;
  logic        unf;

  int checks = 0;
  int errors = 0;

  pc_ras_unit #(
    .WIDTH     (32),
    .DEPTH     (4),
    .RESET_VEC (32'h0)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .LdEn      (ld_en),
    .Sel       (sel),
    .BrTaken   (br_taken),
    .Imm       (imm),
    .Target    (target),
    .Call      (call),
    .Dout      (dout),
    .DoutPlus4 (dout_p4),
    .RasDepth  (depth),
    .RasOvf    (ovf),
    .RasUnf    (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] s, input logic br,
                      input logic [15:0] im, input logic [31:0] tg,
                      input logic c);
    sel      = s;
    br_taken = br;
    imm      = im;
    target   = tg;
    call     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] tg);
    step(2'b10, 1'b0, 16'h0, tg, 1'b0);
  endtask

  initial begin
    logic [31:0] pcs [5];
    logic [31:0] rets [4];
    pcs  = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    rets = '{32'h54, 32'h44, 32'h34, 32'h24};

    reset = 1'b1; ld_en = 1'b0; sel = 2'b00; br_taken = 1'b0;
    imm = '0; target = '0; call = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_depth", {29'b0, depth}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_unf", {31'b0, unf}, 32'd0);
    chk("rst_p4", dout_p4, 32'h4);

    reset = 1'b0; ld_en = 1'b1;
    step(2'b00, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("seq1", dout, 32'h4);
    step(2'b00, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("seq2", dout, 32'h8);
    step(2'b00, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("seq3", dout, 32'hC);

    jump(32'h20);
    chk("jmp20", dout, 32'h20);
    step(2'b01, 1'b1, 16'hFFFE, 32'h0, 1'b0);
    chk("br_neg", dout, 32'h1C);
    jump(32'h20);
    step(2'b01, 1'b0, 16'hFFFE, 32'h0, 1'b0);
    chk("br_nt", dout, 32'h24);
    step(2'b01, 1'b1, 16'h0003, 32'h0, 1'b0);
    chk("br_pos", dout, 32'h34);
    step(2'b00, 1'b0, 16'h0, 32'h0, 1'b1);
    chk("call_ign_seq", {29'b0, depth}, 32'd0);

    jump(32'h40);
    step(2'b10, 1'b0, 16'h0, 32'h103, 1'b1);
    chk("jal_dout", dout, 32'h100);
    chk("jal_depth", {29'b0, depth}, 32'd1);
    step(2'b11, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("ret_dout", dout, 32'h44);
    chk("ret_depth", {29'b0, depth}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      jump(pcs[i]);
      step(2'b10, 1'b0, 16'h0, 32'h200, 1'b1);
      if (i == 3) chk("ovf_pre", {31'b0, ovf}, 32'd0);
    end
    chk("ovf_set", {31'b0, ovf}, 32'd1);
    chk("ovf_depth", {29'b0, depth}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b0, 16'h0, 32'h0, 1'b0);
      chk($sformatf("pop%0d", i), dout, rets[i]);
    end
    chk("pop_depth", {29'b0, depth}, 32'd0);
    chk("unf_pre", {31'b0, unf}, 32'd0);
    step(2'b11, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("unf_dout", dout, 32'h28);
    chk("unf_set", {31'b0, unf}, 32'd1);
    chk("unf_depth", {29'b0, depth}, 32'd0);

    step(2'b10, 1'b0, 16'h0, 32'h300, 1'b1);
    chk("pre_stall", dout, 32'h300);
    ld_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b0, 16'h0, 32'h400, 1'b1);
      chk($sformatf("stall_dout%0d", i), dout, 32'h300);
      chk($sformatf("stall_depth%0d", i), {29'b0, depth}, 32'd1);
    end
    chk("flags_held", {30'b0, ovf, unf}, 32'd3);
    ld_en = 1'b1;
    step(2'b11, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("post_stall_ret", dout, 32'h2C);

    jump(32'hFFFF_FFFC);
    chk("p4_wrap", dout_p4, 32'h0);
    step(2'b00, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("wrap", dout, 32'h0);

    jump(32'h80);
    reset = 1'b1;
    step(2'b10, 1'b0, 16'h0, 32'h500, 1'b1);
    chk("rst_call_dout", dout, 32'h0);
    chk("rst_call_depth", {29'b0, depth}, 32'd0);
    chk("rst_call_flags", {30'b0, ovf, unf}, 32'd0);
    reset = 1'b0;
    step(2'b11, 1'b0, 16'h0, 32'h0, 1'b0);
    chk("rst_ret_unf", dout, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
